// File: rtl/stopwatch_core.sv
// stopwatch_core: tick-driven stopwatch with BCD cs/sec/min counters, phase-preserving
// pause/resume, a show-ahead lap FIFO and a sticky minute-wrap overflow flag.
module stopwatch_core #(
   parameter int unsigned TICK_DIV  = 100,
   parameter int unsigned MAX_MIN   = 60,
   parameter int unsigned LAP_DEPTH = 4
) (
   input  logic        clk_10000Hz,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   input  logic        lap_rd,
   output logic        running,
   output logic [7:0]  cs_bcd,
   output logic [7:0]  sec_bcd,
   output logic [7:0]  min_bcd,
   output logic [23:0] lap_time,
   output logic        lap_valid,
   output logic        lap_full,
   output logic        overflow
);
   localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned   AW         = $clog2(LAP_DEPTH);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [7:0]    MIN_LAST   = {4'((MAX_MIN - 1) / 10), 4'((MAX_MIN - 1) % 10)};

   typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic          tick;
   logic [7:0]    cs_next, sec_next, min_next;
   logic          ovf_next;

   logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next;
   logic [23:0]   mem [LAP_DEPTH];
   logic [23:0]   now_time, head_next;
   logic          empty, full, do_push, do_pop;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r[3:0] = v[3:0] + 4'd1;
         r[7:4] = v[7:4];
      end
      return r;
   endfunction

   always_comb begin
      state_next = state;
      if (clear)
         state_next = STOPPED;
      else if (start_stop)
         state_next = (state == RUNNING) ? STOPPED : RUNNING;
   end

   // A terminal count still ticks in the cycle start_stop stops the watch.
   assign tick = (state == RUNNING) && (presc == PRESC_LAST) && !clear;

   always_comb begin
      presc_next = presc;
      if (clear)
         presc_next = '0;
      else if (state == RUNNING)
         presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
   end

   always_comb begin
      cs_next  = cs_bcd;
      sec_next = sec_bcd;
      min_next = min_bcd;
      ovf_next = overflow;
      if (clear) begin
         cs_next  = '0;
         sec_next = '0;
         min_next = '0;
         ovf_next = 1'b0;
      end else if (tick) begin
         cs_next = bcd_inc(cs_bcd);
         if (cs_bcd == 8'h99) begin
            if (sec_bcd == 8'h59) begin
               sec_next = '0;
               if (min_bcd == MIN_LAST) begin
                  min_next = '0;
                  ovf_next = 1'b1;
               end else begin
                  min_next = bcd_inc(min_bcd);
               end
            end else begin
               sec_next = bcd_inc(sec_bcd);
            end
         end
      end
   end

   assign now_time = {min_bcd, sec_bcd, cs_bcd};
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = lap_rd && !empty && !clear;
   assign do_push  = lap && !clear && (!full || do_pop);

   // The registered head must see a push that lands in the slot becoming the head.
   always_comb begin
      wr_next = wr_ptr;
      rd_next = rd_ptr;
      if (clear) begin
         wr_next = '0;
         rd_next = '0;
      end else begin
         if (do_push) wr_next = wr_ptr + 1'b1;
         if (do_pop)  rd_next = rd_ptr + 1'b1;
      end
      if (rd_next == wr_next)
         head_next = '0;
      else if (do_push && (rd_next == wr_ptr))
         head_next = now_time;
      else
         head_next = mem[rd_next[AW-1:0]];
   end

   always_ff @(posedge clk_10000Hz or posedge reset) begin
      if (reset) begin
         state     <= STOPPED;
         running   <= 1'b0;
         presc     <= '0;
         cs_bcd    <= '0;
         sec_bcd   <= '0;
         min_bcd   <= '0;
         overflow  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         lap_time  <= '0;
         lap_valid <= 1'b0;
         lap_full  <= 1'b0;
      end else begin
         state     <= state_next;
         running   <= (state_next == RUNNING);
         presc     <= presc_next;
         cs_bcd    <= cs_next;
         sec_bcd   <= sec_next;
         min_bcd   <= min_next;
         overflow  <= ovf_next;
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         lap_time  <= head_next;
         lap_valid <= (rd_next != wr_next);
         lap_full  <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
      end
   end

   always_ff @(posedge clk_10000Hz) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= now_time;
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a default-parameter instance and a fast
// TICK_DIV=1 / MAX_MIN=2 instance share the control inputs.
module tb_stopwatch_core;
   logic clk = 1'b0;
   logic reset = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;

   logic        a_running, a_lap_valid, a_lap_full, a_overflow;
   logic [7:0]  a_cs, a_sec, a_min;
   logic [23:0] a_lap_time;
   logic        b_running, b_lap_valid, b_lap_full, b_overflow;
   logic [7:0]  b_cs, b_sec, b_min;
   logic [23:0] b_lap_time;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_core #(.TICK_DIV(100), .MAX_MIN(60), .LAP_DEPTH(4)) dut_a (
      .clk_10000Hz(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
      .lap(lap), .lap_rd(lap_rd), .running(a_running), .cs_bcd(a_cs),
      .sec_bcd(a_sec), .min_bcd(a_min), .lap_time(a_lap_time),
      .lap_valid(a_lap_valid), .lap_full(a_lap_full), .overflow(a_overflow));

   stopwatch_core #(.TICK_DIV(1), .MAX_MIN(2), .LAP_DEPTH(4)) dut_b (
      .clk_10000Hz(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
      .lap(lap), .lap_rd(lap_rd), .running(b_running), .cs_bcd(b_cs),
      .sec_bcd(b_sec), .min_bcd(b_min), .lap_time(b_lap_time),
      .lap_valid(b_lap_valid), .lap_full(b_lap_full), .overflow(b_overflow));

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; cyc(1); start_stop = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; cyc(1); clear = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1; cyc(1); lap = 1'b0;
   endtask

   task automatic pulse_rd();
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
   endtask

   task automatic test_reset();
      logic [51:0] va, vb;
      reset = 1'b1;
      cyc(1);
      va = {a_running, a_cs, a_sec, a_min, a_lap_time, a_lap_valid, a_lap_full, a_overflow};
      vb = {b_running, b_cs, b_sec, b_min, b_lap_time, b_lap_valid, b_lap_full, b_overflow};
      checks++;
      if (va !== 52'h0) begin
         errors++; $display("FAIL reset_a got %h exp %h", va, 52'h0);
      end
      checks++;
      if (vb !== 52'h0) begin
         errors++; $display("FAIL reset_b got %h exp %h", vb, 52'h0);
      end
      reset = 1'b0;
      cyc(10);
      checks++;
      if ({a_running, a_cs} !== 9'h0) begin
         errors++; $display("FAIL reset_idle got %h exp %h", {a_running, a_cs}, 9'h0);
      end
   endtask

   task automatic test_defaults();
      do_reset();
      pulse_ss();
      cyc(99);
      checks++;
      if ({a_running, a_cs} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL pre_first_tick got %h exp %h", {a_running, a_cs}, {1'b1, 8'h00});
      end
      cyc(1);
      checks++;
      if ({a_sec, a_cs} !== 16'h0001) begin
         errors++; $display("FAIL first_tick got %h exp %h", {a_sec, a_cs}, 16'h0001);
      end
      cyc(9900);
      checks++;
      if ({a_running, a_min, a_sec, a_cs} !== {1'b1, 24'h000100}) begin
         errors++; $display("FAIL one_second got %h exp %h", {a_running, a_min, a_sec, a_cs}, {1'b1, 24'h000100});
      end
   endtask

   task automatic test_pause_resume();
      do_reset();
      pulse_ss();
      cyc(149);
      pulse_ss();
      checks++;
      if ({a_running, a_cs} !== {1'b0, 8'h01}) begin
         errors++; $display("FAIL paused got %h exp %h", {a_running, a_cs}, {1'b0, 8'h01});
      end
      cyc(500);
      checks++;
      if ({a_running, a_cs} !== {1'b0, 8'h01}) begin
         errors++; $display("FAIL held got %h exp %h", {a_running, a_cs}, {1'b0, 8'h01});
      end
      pulse_ss();
      cyc(49);
      checks++;
      if ({a_running, a_cs} !== {1'b1, 8'h01}) begin
         errors++; $display("FAIL resume_49 got %h exp %h", {a_running, a_cs}, {1'b1, 8'h01});
      end
      cyc(1);
      checks++;
      if (a_cs !== 8'h02) begin
         errors++; $display("FAIL resume_50 got %h exp %h", a_cs, 8'h02);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      pulse_ss();
      cyc(11999);
      checks++;
      if ({b_min, b_sec, b_cs, b_overflow} !== {24'h015999, 1'b0}) begin
         errors++; $display("FAIL pre_wrap got %h exp %h", {b_min, b_sec, b_cs, b_overflow}, {24'h015999, 1'b0});
      end
      cyc(1);
      checks++;
      if ({b_min, b_sec, b_cs, b_overflow} !== {24'h000000, 1'b1}) begin
         errors++; $display("FAIL wrap got %h exp %h", {b_min, b_sec, b_cs, b_overflow}, {24'h000000, 1'b1});
      end
      cyc(100);
      checks++;
      if ({b_min, b_sec, b_cs, b_overflow} !== {24'h000100, 1'b1}) begin
         errors++; $display("FAIL post_wrap got %h exp %h", {b_min, b_sec, b_cs, b_overflow}, {24'h000100, 1'b1});
      end
      pulse_clear();
      checks++;
      if ({b_running, b_overflow, b_min, b_sec, b_cs} !== 26'h0) begin
         errors++; $display("FAIL wrap_clear got %h exp %h", {b_running, b_overflow, b_min, b_sec, b_cs}, 26'h0);
      end
   endtask

   task automatic test_laps();
      logic [23:0] exp_laps [4];
      exp_laps[0] = 24'h000005; exp_laps[1] = 24'h000010;
      exp_laps[2] = 24'h000015; exp_laps[3] = 24'h000020;
      do_reset();
      pulse_ss();
      cyc(5);  pulse_lap();
      cyc(4);  pulse_lap();
      cyc(4);  pulse_lap();
      cyc(4);  pulse_lap();
      checks++;
      if ({b_lap_full, b_lap_valid, b_lap_time} !== {2'b11, 24'h000005}) begin
         errors++; $display("FAIL lap_fill got %h exp %h", {b_lap_full, b_lap_valid, b_lap_time}, {2'b11, 24'h000005});
      end
      cyc(4);
      checks++;
      if (b_cs !== 8'h25) begin
         errors++; $display("FAIL lap_cs25 got %h exp %h", b_cs, 8'h25);
      end
      pulse_lap();
      pulse_ss();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({b_lap_full, b_lap_valid, b_lap_time} !== {(i == 0), 1'b1, exp_laps[i]}) begin
            errors++; $display("FAIL lap_pop%0d got %h exp %h", i, {b_lap_full, b_lap_valid, b_lap_time}, {(i == 0), 1'b1, exp_laps[i]});
         end
         pulse_rd();
      end
      checks++;
      if ({b_lap_full, b_lap_valid, b_lap_time} !== 26'h0) begin
         errors++; $display("FAIL lap_empty got %h exp %h", {b_lap_full, b_lap_valid, b_lap_time}, 26'h0);
      end
      pulse_rd();
      checks++;
      if ({b_lap_full, b_lap_valid, b_lap_time} !== 26'h0) begin
         errors++; $display("FAIL lap_rd_empty got %h exp %h", {b_lap_full, b_lap_valid, b_lap_time}, 26'h0);
      end
   endtask

   task automatic test_simultaneous();
      logic [23:0] exp_laps [4];
      exp_laps[0] = 24'h000003; exp_laps[1] = 24'h000004;
      exp_laps[2] = 24'h000005; exp_laps[3] = 24'h000006;
      do_reset();
      pulse_ss();
      cyc(10);
      pulse_lap();
      cyc(3);
      clear = 1'b1; start_stop = 1'b1; lap = 1'b1;
      cyc(1);
      clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
      checks++;
      if ({b_running, b_min, b_sec, b_cs, b_overflow, b_lap_valid, b_lap_full, b_lap_time} !== 52'h0) begin
         errors++; $display("FAIL clear_prio got %h exp %h", {b_running, b_min, b_sec, b_cs, b_overflow, b_lap_valid, b_lap_full, b_lap_time}, 52'h0);
      end
      cyc(5);
      checks++;
      if ({b_running, b_cs} !== 9'h0) begin
         errors++; $display("FAIL clear_stays got %h exp %h", {b_running, b_cs}, 9'h0);
      end

      pulse_ss();
      cyc(2);
      lap = 1'b1; cyc(4); lap = 1'b0;
      checks++;
      if ({b_lap_full, b_lap_time} !== {1'b1, 24'h000002}) begin
         errors++; $display("FAIL full_fill got %h exp %h", {b_lap_full, b_lap_time}, {1'b1, 24'h000002});
      end
      lap = 1'b1; lap_rd = 1'b1; cyc(1); lap = 1'b0; lap_rd = 1'b0;
      checks++;
      if ({b_lap_full, b_lap_valid, b_lap_time} !== {2'b11, 24'h000003}) begin
         errors++; $display("FAIL push_pop_full got %h exp %h", {b_lap_full, b_lap_valid, b_lap_time}, {2'b11, 24'h000003});
      end
      pulse_ss();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({b_lap_valid, b_lap_time} !== {1'b1, exp_laps[i]}) begin
            errors++; $display("FAIL pp_pop%0d got %h exp %h", i, {b_lap_valid, b_lap_time}, {1'b1, exp_laps[i]});
         end
         pulse_rd();
      end
      checks++;
      if (b_lap_valid !== 1'b0) begin
         errors++; $display("FAIL pp_empty got %h exp %h", b_lap_valid, 1'b0);
      end

      do_reset();
      pulse_ss();
      cyc(99);
      pulse_ss();
      checks++;
      if ({a_running, a_cs} !== {1'b0, 8'h01}) begin
         errors++; $display("FAIL stop_on_tick got %h exp %h", {a_running, a_cs}, {1'b0, 8'h01});
      end
      cyc(200);
      checks++;
      if ({a_running, a_cs} !== {1'b0, 8'h01}) begin
         errors++; $display("FAIL stop_on_tick_hold got %h exp %h", {a_running, a_cs}, {1'b0, 8'h01});
      end

      do_reset();
      pulse_ss();
      cyc(98);
      pulse_ss();
      pulse_ss();
      checks++;
      if ({a_running, a_cs} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL start_on_term got %h exp %h", {a_running, a_cs}, {1'b1, 8'h00});
      end
      cyc(1);
      checks++;
      if (a_cs !== 8'h01) begin
         errors++; $display("FAIL start_on_term_tick got %h exp %h", a_cs, 8'h01);
      end
   endtask

   task automatic test_async_reset();
      logic [51:0] vb;
      do_reset();
      pulse_ss();
      cyc(10);
      pulse_lap();
      cyc(20);
      pulse_lap();
      cyc(315);
      checks++;
      if ({b_min, b_sec, b_cs, b_lap_valid, b_lap_time} !== {24'h000347, 1'b1, 24'h000010}) begin
         errors++; $display("FAIL pre_reset got %h exp %h", {b_min, b_sec, b_cs, b_lap_valid, b_lap_time}, {24'h000347, 1'b1, 24'h000010});
      end
      #2 reset = 1'b1;
      #1;
      vb = {b_running, b_cs, b_sec, b_min, b_lap_time, b_lap_valid, b_lap_full, b_overflow};
      checks++;
      if (vb !== 52'h0) begin
         errors++; $display("FAIL async_reset got %h exp %h", vb, 52'h0);
      end
      reset = 1'b0;
      cyc(20);
      checks++;
      if ({b_running, b_cs, b_lap_valid} !== 10'h0) begin
         errors++; $display("FAIL post_reset_idle got %h exp %h", {b_running, b_cs, b_lap_valid}, 10'h0);
      end
      pulse_ss();
      cyc(5);
      checks++;
      if ({b_running, b_cs} !== {1'b1, 8'h05}) begin
         errors++; $display("FAIL post_reset_run got %h exp %h", {b_running, b_cs}, {1'b1, 8'h05});
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_pause_resume();
      test_wrap();
      test_laps();
      test_simultaneous();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
